// File: rtl/parity_tx_serializer.sv
// Parallel-to-serial transmitter: shifts a data word out LSB-first over a
// valid/ready stream and appends one generated (even/odd) parity bit.
module parity_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_mode,
    input  logic                  inject_err,
    output logic                  ser_data,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  ser_is_parity,
    output logic [CNT_W-1:0]      bit_idx,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  par_q, par_n;
    logic                  ser_data_q, ser_data_n;
    logic [CNT_W-1:0]      idx_q, idx_n;
    logic                  done_q, done_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            par_q      <= 1'b0;
            ser_data_q <= 1'b0;
            idx_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            par_q      <= par_n;
            ser_data_q <= ser_data_n;
            idx_q      <= idx_n;
            done_q     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        par_n      = par_q;
        ser_data_n = ser_data_q;
        idx_n      = idx_q;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    // Mode and inject flag are folded into the parity bit at acceptance.
                    state_n    = DATA;
                    shreg_n    = in_data;
                    par_n      = (^in_data) ^ in_mode ^ inject_err;
                    idx_n      = '0;
                    ser_data_n = in_data[0];
                end
            end
            DATA: begin
                if (ser_ready) begin
                    if (idx_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_n    = PARITY;
                        idx_n      = CNT_W'(DATA_WIDTH);
                        ser_data_n = par_q;
                    end else begin
                        shreg_n    = shreg >> 1;
                        idx_n      = idx_q + 1'b1;
                        ser_data_n = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (ser_ready) begin
                    state_n    = IDLE;
                    idx_n      = '0;
                    ser_data_n = 1'b0;
                    done_n     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready      = (state == IDLE);
    assign ser_valid     = (state != IDLE);
    assign ser_is_parity = (state == PARITY);
    assign ser_data      = ser_data_q;
    assign bit_idx       = idx_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_parity_tx_serializer.sv
// Self-checking bench for parity_tx_serializer: directed frames plus random
// traffic compared against a queue-of-expected-bits reference model.
module tb_parity_tx_serializer;

    localparam int DW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_mode;
    logic          inject_err;
    logic          ser_data;
    logic          ser_valid;
    logic          ser_ready;
    logic          ser_is_parity;
    logic [CW-1:0] bit_idx;
    logic          frame_done;

    parity_tx_serializer #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_mode       (in_mode),
        .inject_err    (inject_err),
        .ser_data      (ser_data),
        .ser_valid     (ser_valid),
        .ser_ready     (ser_ready),
        .ser_is_parity (ser_is_parity),
        .bit_idx       (bit_idx),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: bits still to be sent for the current frame.
    bit exp_q[$];
    int exp_idx     = 0;
    bit exp_done    = 1'b0;
    bit frame_xor   = 1'b0;
    bit rx_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: apply inputs, advance the model, then check every output.
    task automatic step(input bit rst, input bit v, input logic [DW-1:0] d,
                        input bit m, input bit e, input bit r, output bit acc);
        bit nd;
        bit x;
        reset      = rst;
        in_valid   = v;
        in_data    = d;
        in_mode    = m;
        inject_err = e;
        ser_ready  = r;
        acc = !rst && v && (in_ready === 1'b1);
        nd  = 1'b0;
        if (rst) begin
            exp_q.delete();
            rx_q.delete();
            exp_idx = 0;
        end else if (exp_q.size() == 0) begin
            if (v) begin
                for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
                exp_q.push_back((^d) ^ m ^ e);
                exp_idx   = 0;
                frame_xor = m ^ e;
                rx_q.delete();
            end
        end else if (r) begin
            rx_q.push_back(ser_data);
            void'(exp_q.pop_front());
            exp_idx++;
            if (exp_q.size() == 0) begin
                exp_idx = 0;
                nd = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_done = nd;
        check_val("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
        check_val("ser_valid", 32'(ser_valid), 32'(exp_q.size() != 0));
        check_val("ser_is_parity", 32'(ser_is_parity), 32'(exp_q.size() == 1));
        check_val("bit_idx", 32'(bit_idx), 32'(exp_idx));
        check_val("frame_done", 32'(frame_done), 32'(exp_done));
        if (exp_q.size() != 0) check_val("ser_data", 32'(ser_data), 32'(exp_q[0]));
        if (rst) check_val("ser_data_rst", 32'(ser_data), 32'd0);
        if (nd) begin
            x = 1'b0;
            foreach (rx_q[i]) x ^= rx_q[i];
            check_val("frame_bits", 32'(rx_q.size()), 32'(DW + 1));
            check_val("frame_xor", 32'(x), 32'(frame_xor));
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit m, input bit e);
        bit acc;
        step(0, 1, d, m, e, 1, acc);
        check_val("accept", 32'(acc), 32'd1);
        for (int i = 0; i < DW + 2; i++) step(0, 0, '0, 0, 0, 1, acc);
    endtask

    initial begin
        bit acc;
        int last_acc;
        int n_acc;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        inject_err = 1'b0; ser_ready = 1'b0;
        step(1, 0, '0, 0, 0, 0, acc);
        step(1, 1, 8'h5A, 0, 0, 1, acc);

        send(8'hA5, 0, 0);
        send(8'h07, 1, 0);
        send(8'h07, 0, 0);
        send(8'hFF, 0, 1);

        // Backpressure with ready pattern 1,0,0,1,...
        step(0, 1, 8'h3C, 0, 0, 1, acc);
        for (int i = 0; i < 40; i++) step(0, 0, '0, 0, 0, (i % 3) == 0, acc);

        // Reset in the middle of a frame, then a clean frame.
        step(0, 1, 8'hC3, 1, 0, 1, acc);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 0, 1, acc);
        check_val("idx_before_reset", 32'(bit_idx), 32'd4);
        step(1, 0, '0, 0, 0, 1, acc);
        step(0, 0, '0, 0, 0, 1, acc);
        send(8'h96, 1, 0);

        // in_valid held high with changing data: back-to-back frame period.
        last_acc = -1;
        n_acc = 0;
        for (int i = 0; i < 42; i++) begin
            step(0, 1, DW'($urandom), 1'($urandom), 1'($urandom), 1, acc);
            if (acc) begin
                if (last_acc >= 0) check_val("period", 32'(cyc - last_acc), 32'(DW + 2));
                last_acc = cyc;
                n_acc++;
            end
        end
        check_val("accept_count", 32'(n_acc), 32'd5);
        for (int i = 0; i < DW + 2; i++) step(0, 0, '0, 0, 0, 1, acc);

        // Random traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, DW'($urandom),
                 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_tx_serializer.md
Name: parity_tx_serializer

Overview:
Transmit-side companion to the serial parity checker. Accepts a parallel data word with an even/odd mode and shifts it out LSB-first, one bit per handshake, on a valid-qualified serial stream. After the data bits it appends one generated parity bit. The block sources test and link traffic for the receive-side parity checker.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (range 2..16).
CNT_W, 5, width of the bit index counter; must satisfy 2^CNT_W > DATA_WIDTH.

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high; sampled on rising clk edge
in_valid  input  1  parallel word offered
in_ready  output  1  block can accept a word (IDLE only)
in_data  input  DATA_WIDTH  word to transmit
in_mode  input  1  0 = even parity, 1 = odd parity
inject_err  input  1  when high at acceptance, the generated parity bit is inverted for this frame
ser_data  output  1  serial bit
ser_valid  output  1  ser_data is meaningful
ser_ready  input  1  downstream accepts the current bit
ser_is_parity  output  1  current serial bit is the parity bit
bit_idx  output  CNT_W  index of the current bit: 0..DATA_WIDTH-1 for data, DATA_WIDTH for parity
frame_done  output  1  one-cycle pulse after the parity bit is accepted

Behaviour:
- Reset (synchronous, active-high): state=IDLE; in_ready=1; ser_data=0; ser_valid=0; ser_is_parity=0; bit_idx=0; frame_done=0. Shift register, latched mode and latched inject flag are cleared.
- Reset mid-frame abandons the frame; the block does not resume it. Reset has priority over every other event.
- States: IDLE, DATA, PARITY.
- IDLE: in_ready=1, ser_valid=0. Acceptance occurs when in_valid=1 at a clock edge.
  - On acceptance, latch in_data into the shift register, latch in_mode and inject_err, compute the parity bit, and go to DATA.
  - Set bit_idx=0 and ser_data=in_data[0].
- Parity bit p = (^in_data) XOR in_mode XOR inject_err.
  - With inject_err=0, the XOR of all DATA_WIDTH+1 transmitted bits equals in_mode.
- DATA: ser_valid=1, in_ready=0, ser_is_parity=0.
  - A bit transfers on a clock edge where ser_valid=1 and ser_ready=1.
  - On transfer with bit_idx<DATA_WIDTH-1: shift right and increment bit_idx.
  - On transfer with bit_idx=DATA_WIDTH-1: go to PARITY, set bit_idx=DATA_WIDTH, set ser_data=p.
- PARITY: ser_valid=1, ser_is_parity=1.
  - On transfer: go to IDLE, pulse frame_done=1 for exactly one cycle, drive ser_valid=0, and reset bit_idx to 0.
- Backpressure: while ser_ready=0, ser_data, ser_valid, ser_is_parity and bit_idx hold unchanged. No bit is skipped or duplicated.
- in_valid during DATA or PARITY is ignored and not queued. in_data, in_mode and inject_err changes after acceptance do not affect the frame in flight.
- Latency and throughput:
  - First data bit is valid in the cycle after acceptance.
  - With ser_ready held at 1, a frame occupies DATA_WIDTH+1 ser_valid cycles, plus 1 IDLE cycle before the next acceptance.
  - Minimum period is DATA_WIDTH+2 cycles.
- frame_done asserts in the IDLE cycle that follows the parity transfer. in_ready is also 1 in that cycle, so a new acceptance may coincide with frame_done.
- All outputs are registered. No combinational path exists from ser_ready to ser_valid, or from in_valid to in_ready.

Test Plan:
- Reset, then in_data=8'hA5, in_mode=0, ser_ready=1 -> ser_data sequence 1,0,1,0,0,1,0,1 then parity 0; ser_is_parity=1 only on the 9th bit; frame_done one cycle later; in_ready=1.
- in_data=8'h07, in_mode=1 -> data bits 1,1,1,0,0,0,0,0, parity 0. Repeat with in_mode=0 -> parity 1. Feeding either stream to the parity checker gives parity_ok=1.
- in_data=8'h3C, in_mode=0, with ser_ready toggling 1,0,0,1,... -> outputs hold during ser_ready=0; exactly 9 transfers occur; parity 0; bit_idx runs 0..8 monotonically.
- in_data=8'hFF, in_mode=0, inject_err=1 -> parity bit 1 instead of 0; the parity checker reports failure.
- Reset asserted at bit_idx=4 of a frame -> next cycle ser_valid=0, in_ready=1, bit_idx=0, no frame_done. A new word then transmits cleanly.
- in_valid held high with changing in_data during a frame -> in-flight bits unaffected. The next word is accepted only in the frame_done/IDLE cycle, giving a 10-cycle frame period.
